// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] i_Addr);
    return {i_Addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {instr, pc} pairs between memory return and decode.
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic         i_Push,
  input  logic         i_Pop,
  input  logic         i_Flush,
  input  fetch_entry_t i_Entry,
  output fetch_entry_t o_Head,
  output logic [1:0]   o_Count
);

  fetch_entry_t r_Entries [2];
  logic         r_RdPtr;
  logic         r_WrPtr;
  logic [1:0]   r_Count;

  logic w_DoPop;
  logic w_DoPush;

  assign w_DoPop  = i_Pop && (r_Count != 2'd0);
  // A push into a full buffer is fine when the head leaves on the same edge.
  assign w_DoPush = i_Push && ((r_Count != 2'd2) || w_DoPop);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Entries[0] <= '0;
      r_Entries[1] <= '0;
      r_RdPtr      <= 1'b0;
      r_WrPtr      <= 1'b0;
      r_Count      <= 2'd0;
    end else if (i_Flush) begin
      r_RdPtr <= 1'b0;
      r_WrPtr <= 1'b0;
      r_Count <= 2'd0;
    end else begin
      if (w_DoPush) begin
        r_Entries[r_WrPtr] <= i_Entry;
        r_WrPtr            <= ~r_WrPtr;
      end
      if (w_DoPop) begin
        r_RdPtr <= ~r_RdPtr;
      end
      case ({w_DoPush, w_DoPop})
        2'b10:   r_Count <= r_Count + 2'd1;
        2'b01:   r_Count <= r_Count - 2'd1;
        default: r_Count <= r_Count;
      endcase
    end
  end

  assign o_Head  = r_Entries[r_RdPtr];
  assign o_Count = r_Count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one read per cycle to a 1-cycle-latency memory,
// buffers returned words for decode and handles redirects from execute.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  output logic [XLEN-1:0] o_MemAddress,
  output logic            o_MemWriteEnable,
  output logic [XLEN-1:0] o_MemDataIn,
  input  logic [XLEN-1:0] i_MemData,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectTarget,
  output logic            o_InstrValid,
  input  logic            i_InstrReady,
  output logic [XLEN-1:0] o_Instr,
  output logic [XLEN-1:0] o_InstrPc
);

  localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] r_Pc;
  logic            r_InFlight;
  logic [XLEN-1:0] r_InFlightPc;

  logic [XLEN-1:0] w_FetchPc;
  logic            w_Pop;
  logic            w_Issue;
  logic            w_Push;
  logic [2:0]      w_Occupancy;
  logic [1:0]      w_Count;
  fetch_entry_t    w_Head;
  fetch_entry_t    w_PushEntry;

  assign w_FetchPc = i_Redirect ? align_word(i_RedirectTarget) : r_Pc;
  assign w_Pop     = o_InstrValid && i_InstrReady;

  // Slots that will be claimed after this edge if nothing new is issued.
  assign w_Occupancy = {1'b0, w_Count} + {2'b00, r_InFlight} - {2'b00, w_Pop};
  assign w_Issue     = i_Redirect || (w_Occupancy < 3'd2);

  assign w_Push      = r_InFlight && !i_Redirect;
  assign w_PushEntry = '{instr: i_MemData, pc: r_InFlightPc};

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Pc         <= RESET_PC;
      r_InFlight   <= 1'b0;
      r_InFlightPc <= '0;
    end else if (w_Issue) begin
      r_InFlight   <= 1'b1;
      r_InFlightPc <= w_FetchPc;
      r_Pc         <= w_FetchPc + 32'd4;
    end else begin
      r_InFlight   <= 1'b0;
    end
  end

  fetch_buffer u_fetch_buffer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (w_Push),
    .i_Pop   (w_Pop),
    .i_Flush (i_Redirect),
    .i_Entry (w_PushEntry),
    .o_Head  (w_Head),
    .o_Count (w_Count)
  );

  assign o_MemAddress     = {2'b00, w_FetchPc[XLEN-1:2]};
  assign o_MemWriteEnable = 1'b0;
  assign o_MemDataIn      = '0;

  assign o_InstrValid = (w_Count != 2'd0);
  assign o_Instr      = w_Head.instr;
  assign o_InstrPc    = w_Head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table plus randomized stream checking.
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_data;
  logic        redir;
  logic [31:0] target;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .o_MemAddress     (mem_addr),
    .o_MemWriteEnable (mem_we),
    .o_MemDataIn      (mem_din),
    .i_MemData        (mem_data),
    .i_Redirect       (redir),
    .i_RedirectTarget (target),
    .o_InstrValid     (valid),
    .i_InstrReady     (ready),
    .o_Instr          (instr),
    .o_InstrPc        (instr_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word k holds A000_0000 + k.
  always @(posedge clk) mem_data <= 32'hA000_0000 + {16'h0, mem_addr[15:0]};

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hA000_0000 + {16'h0, pc[17:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    ready  = rdy;
    redir  = rd;
    target = tgt;
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] target;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [23];

  logic [31:0] exp_pc;
  logic        v_known;
  logic        v_exp;
  logic        prev_rd;
  logic        rdy_r;
  logic        rd_r;
  logic [31:0] tgt_r;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0040};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0041};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 32'h0000_0042};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 32'h0000_0043};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0108, 32'h0000_0044};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_010C, 32'h0000_0045};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0110, 32'h0000_0046};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0203, 1'b1, 32'h0000_0110, 32'h0000_0080};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0081};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200, 32'h0000_0082};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0204, 32'h0000_0100};
    vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_0101};
    vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0400, 32'h0000_0102};
    vecs[18] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_0404, 32'h3FFF_FFFE};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h3FFF_FFFF};
    vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[21] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0001};
    vecs[22] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'h0000_0002};

    rst = 1'b1; ready = 1'b0; redir = 1'b0; target = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_valid", {31'h0, valid}, 32'h0);
    chk("reset_addr", mem_addr, 32'h0000_0040);
    chk("reset_we", {31'h0, mem_we}, 32'h0);
    chk("reset_din", mem_din, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].ready, vecs[i].redir, vecs[i].target);
      chk($sformatf("vec%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), instr, word_at(vecs[i].exp_pc));
      end
    end

    // Asynchronous reset mid-stream must drop valid before any clock edge.
    drive(1'b1, 1'b0, 32'h0);
    chk("pre_async_valid", {31'h0, valid}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, valid}, 32'h0);
    chk("async_rst_addr", mem_addr, 32'h0000_0040);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    chk("restart_c0_valid", {31'h0, valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    chk("restart_c1_valid", {31'h0, valid}, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    chk("restart_c2_valid", {31'h0, valid}, 32'h1);
    chk("restart_c2_pc", instr_pc, 32'h0000_0100);
    chk("restart_c2_instr", instr, 32'hA000_0040);

    // Randomized stream: consumed PCs must be consecutive from the last redirect.
    exp_pc  = 32'h0000_0100;
    v_known = 1'b1;
    v_exp   = 1'b1;
    prev_rd = 1'b0;
    rdy_r   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c == 0) begin
        rd_r = 1'b0; tgt_r = 32'h0;
      end else begin
        rdy_r = ($urandom_range(9) < 7);
        rd_r  = ($urandom_range(11) == 0);
        tgt_r = $urandom;
        if ($urandom_range(3) == 0) tgt_r = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        drive(rdy_r, rd_r, tgt_r);
      end
      if (v_known) chk("rand_valid", {31'h0, valid}, {31'h0, v_exp});
      if (valid) begin
        chk("rand_pc", instr_pc, exp_pc);
        chk("rand_instr", instr, word_at(exp_pc));
      end
      if (rd_r) chk("rand_redir_addr", mem_addr, {2'b00, tgt_r[31:2]});
      if (rd_r) begin
        v_known = 1'b1; v_exp = 1'b0;
      end else if (prev_rd || valid) begin
        v_known = 1'b1; v_exp = 1'b1;
      end else begin
        v_known = 1'b0; v_exp = 1'b0;
      end
      if (valid && rdy_r) exp_pc = exp_pc + 32'd4;
      if (rd_r) exp_pc = {tgt_r[31:2], 2'b00};
      prev_rd = rd_r;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
